// File: rtl/wb_skid_reg_pkg.sv
// Shared definitions for the MEM->WB skid register: default widths and state encoding.
package wb_skid_reg_pkg;

  localparam int unsigned XlenDefault = 64;
  localparam int unsigned IlenDefault = 32;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StMain  = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake, flush, optional skid entry and
// a saturating back-pressure counter.
module wb_skid_reg
  import wb_skid_reg_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault,
  parameter int unsigned ILEN = IlenDefault,
  parameter int unsigned SKID = 1,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] alures_i,
  input  logic [XLEN-1:0] lsres_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] alures_o,
  output logic [XLEN-1:0] lsres_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  localparam int unsigned PayW = 3 * XLEN + ILEN;

  state_e          r_state;
  state_e          w_state_d;
  logic [PayW-1:0] r_main;
  logic [PayW-1:0] r_skid;
  logic [PayW-1:0] w_in_pay;
  logic [CNTW-1:0] r_stall_cnt;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_in;
  logic            w_load_from_skid;
  logic            w_load_skid;

  assign w_in_pay    = {pc_i, instr_i, alures_i, lsres_i};
  assign out_valid_o = (r_state != StEmpty);
  assign w_in_fire   = in_valid_i & in_ready_o;
  assign w_out_fire  = out_valid_o & out_ready_i;

  assign {pc_o, instr_o, alures_o, lsres_o} = r_main;
  assign stall_cnt_o = r_stall_cnt;

  always_comb begin
    w_state_d        = r_state;
    w_load_in        = 1'b0;
    w_load_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_in_fire) begin
          w_state_d = StMain;
          w_load_in = 1'b1;
        end
      end
      StMain: begin
        if (w_in_fire && w_out_fire) begin
          w_load_in = 1'b1;
        end else if (w_in_fire && (SKID != 0)) begin
          // Head is stalled: park the new entry in the skid slot.
          w_state_d   = StFull;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        if (w_out_fire) begin
          w_state_d        = StMain;
          w_load_from_skid = 1'b1;
        end
      end
      default: w_state_d = StEmpty;
    endcase
    // Flush drops every entry but leaves payload registers untouched.
    if (flush_i) begin
      w_state_d        = StEmpty;
      w_load_in        = 1'b0;
      w_load_from_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StEmpty;
      r_main      <= '0;
      r_skid      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load_in) begin
        r_main <= w_in_pay;
      end else if (w_load_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_pay;
      end
      if (out_valid_o && !out_ready_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  if (SKID != 0) begin : g_skid
    logic r_in_ready;

    // Registered ready: accept whenever the next cycle leaves the skid slot free.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_in_ready <= 1'b1;
      end else begin
        r_in_ready <= (w_state_d != StFull);
      end
    end

    assign in_ready_o = r_in_ready;
  end else begin : g_no_skid
    assign in_ready_o = ~out_valid_o | out_ready_i;
  end

endmodule

// File: tb/tb_wb_skid_reg.sv
// Self-checking bench for wb_skid_reg: directed table, corner sequences and a random run
// checked against a queue-based reference for both skid and no-skid builds.
module tb_wb_skid_reg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned PW   = 3 * XLEN + ILEN;
  localparam logic [63:0] P0   = 64'h8000_0000;

  typedef logic [PW-1:0] pay_t;

  typedef struct {
    bit          flush;
    bit          in_valid;
    bit          out_ready;
    logic [63:0] pc;
    bit          e_valid;
    bit          e_ready;
    logic [63:0] e_pc;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [ILEN-1:0] instr = '0;
  logic [XLEN-1:0] alures = '0;
  logic [XLEN-1:0] lsres = '0;

  logic            a_rdy, a_vld, b_rdy, b_vld;
  logic [XLEN-1:0] a_pc, a_alu, a_ls, b_pc, b_alu, b_ls;
  logic [ILEN-1:0] a_instr, b_instr;
  logic [3:0]      a_cnt;
  logic [15:0]     b_cnt;

  wb_skid_reg #(.XLEN(XLEN), .ILEN(ILEN), .SKID(1), .CNTW(4)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (a_rdy),
    .pc_i       (pc),
    .instr_i    (instr),
    .alures_i   (alures),
    .lsres_i    (lsres),
    .out_valid_o(a_vld),
    .out_ready_i(out_ready),
    .pc_o       (a_pc),
    .instr_o    (a_instr),
    .alures_o   (a_alu),
    .lsres_o    (a_ls),
    .stall_cnt_o(a_cnt)
  );

  wb_skid_reg #(.XLEN(XLEN), .ILEN(ILEN), .SKID(0), .CNTW(16)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (b_rdy),
    .pc_i       (pc),
    .instr_i    (instr),
    .alures_i   (alures),
    .lsres_i    (lsres),
    .out_valid_o(b_vld),
    .out_ready_i(out_ready),
    .pc_o       (b_pc),
    .instr_o    (b_instr),
    .alures_o   (b_alu),
    .lsres_o    (b_ls),
    .stall_cnt_o(b_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  pay_t qa[$];
  pay_t qb[$];
  pay_t last_a = '0;
  pay_t last_b = '0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  bit   erdy_a, erdy_b;
  vec_t tbl[23];

  function automatic pay_t in_pay();
    return {pc, instr, alures, lsres};
  endfunction

  function automatic pay_t a_pay();
    return {a_pc, a_instr, a_alu, a_ls};
  endfunction

  function automatic pay_t b_pay();
    return {b_pc, b_instr, b_alu, b_ls};
  endfunction

  function automatic vec_t mk(bit f, bit iv, bit ordy, logic [63:0] p, bit ev, bit er,
                              logic [63:0] ep);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.pc = p;
    v.e_valid = ev; v.e_ready = er; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input pay_t act, input pay_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit f, input bit iv, input bit ordy, input logic [63:0] p);
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    pc        = p;
    instr     = p[31:0] ^ 32'h1234_5678;
    alures    = ~p;
    lsres     = p * 3;
  endtask

  // Expected outputs follow from the queue contents alone.
  task automatic check_model();
    pay_t exp;
    erdy_a = (qa.size() < 2);
    erdy_b = (qb.size() == 0) || out_ready;
    chk("a_valid", a_vld, qa.size() != 0);
    chk("a_ready", a_rdy, erdy_a);
    if (qa.size() != 0) exp = qa[0]; else exp = last_a;
    chk("a_payload", a_pay(), exp);
    chk("a_stall_cnt", a_cnt, cnt_a);
    chk("b_valid", b_vld, qb.size() != 0);
    chk("b_ready", b_rdy, erdy_b);
    if (qb.size() != 0) exp = qb[0]; else exp = last_b;
    chk("b_payload", b_pay(), exp);
    chk("b_stall_cnt", b_cnt, cnt_b);
  endtask

  task automatic model_update();
    bit fin_a, fout_a, fin_b, fout_b;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0;
      cnt_a = 0; cnt_b = 0;
    end else begin
      fin_a  = in_valid && erdy_a;
      fout_a = (qa.size() != 0) && out_ready;
      fin_b  = in_valid && erdy_b;
      fout_b = (qb.size() != 0) && out_ready;
      if (qa.size() != 0 && !out_ready && cnt_a < 15) cnt_a++;
      if (qb.size() != 0 && !out_ready && cnt_b < 65535) cnt_b++;
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (fout_a) void'(qa.pop_front());
        if (fin_a) qa.push_back(in_pay());
        if (fout_b) void'(qb.pop_front());
        if (fin_b) qb.push_back(in_pay());
      end
      if (qa.size() != 0) last_a = qa[0];
      if (qb.size() != 0) last_b = qb[0];
    end
  endtask

  task automatic cycle();
    #1;
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit   st_a, st_b;
    pay_t prev_a, prev_b;

    for (int k = 0; k < 8; k++) begin
      tbl[k] = mk(0, 1, 1, P0 + 64'(4 * k), k != 0, 1, (k == 0) ? 64'h0 : P0 + 64'(4 * (k - 1)));
    end
    tbl[8]  = mk(0, 0, 1, 64'h0,    1, 1, P0 + 64'd28);
    tbl[9]  = mk(0, 1, 1, 64'h1000, 0, 1, P0 + 64'd28);
    tbl[10] = mk(0, 1, 0, 64'h2000, 1, 1, 64'h1000);
    tbl[11] = mk(0, 1, 0, 64'h3000, 1, 0, 64'h1000);
    tbl[12] = mk(0, 1, 0, 64'h3000, 1, 0, 64'h1000);
    tbl[13] = mk(0, 1, 1, 64'h3000, 1, 0, 64'h1000);
    tbl[14] = mk(0, 1, 1, 64'h3000, 1, 1, 64'h2000);
    tbl[15] = mk(0, 0, 1, 64'h0,    1, 1, 64'h3000);
    tbl[16] = mk(0, 0, 1, 64'h0,    0, 1, 64'h3000);
    tbl[17] = mk(0, 1, 1, 64'h4000, 0, 1, 64'h3000);
    tbl[18] = mk(0, 1, 0, 64'h5000, 1, 1, 64'h4000);
    tbl[19] = mk(1, 1, 0, 64'h6000, 1, 0, 64'h4000);
    tbl[20] = mk(0, 0, 0, 64'h0,    0, 1, 64'h4000);
    tbl[21] = mk(1, 1, 0, 64'h7000, 0, 1, 64'h4000);
    tbl[22] = mk(0, 0, 0, 64'h0,    0, 1, 64'h4000);

    // Reset with live-looking inputs; nothing may be captured.
    rst_n = 1'b0;
    drive(0, 1, 0, 64'hdead_beef_0000_0000);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i[0], 64'hdead_beef_0000_0010 + 64'(i));
      cycle();
    end
    chk("rst_a_valid", a_vld, 0);
    chk("rst_a_ready", a_rdy, 1);
    chk("rst_a_payload", a_pay(), 0);
    chk("rst_b_payload", b_pay(), 0);
    chk("rst_a_cnt", a_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].flush, tbl[i].in_valid, tbl[i].out_ready, tbl[i].pc);
      #1;
      chk($sformatf("row%0d_valid", i), a_vld, tbl[i].e_valid);
      chk($sformatf("row%0d_ready", i), a_rdy, tbl[i].e_ready);
      chk($sformatf("row%0d_pc", i), a_pc, tbl[i].e_pc);
      cycle();
    end

    // Hold one entry under back-pressure long enough to saturate the 4-bit counter.
    drive(0, 1, 1, 64'h8000);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 64'h0);
      cycle();
    end
    chk("sat_a_cnt", a_cnt, 15);
    chk("sat_a_pc", a_pc, 64'h8000);
    chk("sat_a_valid", a_vld, 1);
    drive(0, 0, 1, 64'h0);
    cycle();

    st_a = 0; st_b = 0; prev_a = '0; prev_b = '0;
    for (int n = 0; n < 10000; n++) begin
      if (st_a) chk("a_stable", a_pay(), prev_a);
      if (st_b) chk("b_stable", b_pay(), prev_b);
      rst_n = ($urandom_range(199) != 0);
      drive($urandom_range(29) == 0, $urandom_range(9) < 6, $urandom_range(9) < 6,
            {$urandom, $urandom});
      alures = {$urandom, $urandom};
      lsres  = {$urandom, $urandom};
      st_a = rst_n && !flush && a_vld && !out_ready;
      st_b = rst_n && !flush && b_vld && !out_ready;
      prev_a = a_pay();
      prev_b = b_pay();
      cycle();
    end

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 64'h0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
